// File: rtl/mcdecoder.sv
// Multicycle main decoder FSM with iterative MUL/DIV/POW wait; optional watchdog under DECODER_LONGOP_TIMEOUT_EN.
// Latency: one state per cycle; LONGWAIT holds until LongDone (or TIMEOUT cycles when the watchdog is built in).
// Backpressure: LongDone is the only stall source; Busy marks the stalled state.
module mcdecoder #(
    parameter int ALUCW   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic             LongDone,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             PCS,
    output logic             LongStart,
    output logic             Busy,
    output logic             Fault,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [1:0]       FlagW,
    output logic [ALUCW-1:0] ALUControl
);

    if (ALUCW < 3 || TIMEOUT < 1) begin : g_param_chk
        $error("mcdecoder: ALUCW must be >= 3 and TIMEOUT >= 1");
    end

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, LONGWAIT, ALUWB, BRANCH
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic       alusrca;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       busy;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
    } ctl_t;

    state_t     st, nxt;
    ctl_t       ctl_q;
    logic       islong, addsub, tmo;
    logic [2:0] alu3;

    assign islong = (Op == 2'b00) && (Funct[4:1] inside {4'b0101, 4'b0110, 4'b0111});
    assign addsub = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010);

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.nextpc = 1'b1; c.alusrca = 1'b1;
                            c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            DECODE:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
            MEMADR:   c.alusrcb = 2'b01;
            MEMRD:    c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = 2'b01; c.regw = 1'b1; end
            MEMWR:    begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECI:    c.alusrcb = 2'b01;
            LONGWAIT: c.busy = 1'b1;
            ALUWB:    c.regw = 1'b1;
            BRANCH:   begin c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

`ifdef DECODER_LONGOP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          fault_q;
    assign tmo   = (cnt == CW'(TIMEOUT - 1));
    assign Fault = fault_q & ~reset;
`else
    assign tmo   = 1'b0;
    assign Fault = 1'b0;
`endif

    always_comb begin
        nxt = st;
        case (st)
            FETCH:    nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   nxt = Funct[5] ? EXECI : EXECR;
                    2'b01:   nxt = MEMADR;
                    2'b10:   nxt = BRANCH;
                    default: nxt = FETCH;
                endcase
            end
            MEMADR:   nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    nxt = MEMWB;
            EXECR,
            EXECI:    nxt = islong ? LONGWAIT : ALUWB;
            // A completing result beats the watchdog on the same cycle.
            LONGWAIT: begin
                if (LongDone)  nxt = ALUWB;
                else if (tmo)  nxt = FETCH;
            end
            default:  nxt = FETCH;
        endcase
    end

    // Control outputs are registered from the next state so they line up with st.
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= FETCH;
            ctl_q <= decode(FETCH);
`ifdef DECODER_LONGOP_TIMEOUT_EN
            cnt     <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            st    <= nxt;
            ctl_q <= decode(nxt);
`ifdef DECODER_LONGOP_TIMEOUT_EN
            cnt     <= (st == LONGWAIT && nxt == LONGWAIT) ? cnt + 1'b1 : '0;
            fault_q <= (st == LONGWAIT) && (nxt == FETCH);
`endif
        end
    end

    always_comb begin
        alu3 = 3'd0;
        if (Op == 2'b00) begin
            case (Funct[4:1])
                4'b0010: alu3 = 3'd1;
                4'b0000: alu3 = 3'd2;
                4'b1100: alu3 = 3'd3;
                4'b0101: alu3 = 3'd4;
                4'b0110: alu3 = 3'd5;
                4'b0111: alu3 = 3'd6;
                default: alu3 = 3'd0;
            endcase
        end
    end

    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        if (!reset) begin
            case (Op)
                2'b01:   begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
                2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
                default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
            endcase
        end
    end

    assign IRWrite    = ctl_q.irwrite & ~reset;
    assign NextPC     = ctl_q.nextpc  & ~reset;
    assign AdrSrc     = ctl_q.adrsrc  & ~reset;
    assign ALUSrcA    = ctl_q.alusrca & ~reset;
    assign RegW       = ctl_q.regw    & ~reset;
    assign MemW       = ctl_q.memw    & ~reset;
    assign Branch     = ctl_q.branch  & ~reset;
    assign Busy       = ctl_q.busy    & ~reset;
    assign ALUSrcB    = reset ? 2'b00 : ctl_q.alusrcb;
    assign ResultSrc  = reset ? 2'b00 : ctl_q.resultsrc;
    assign ALUControl = reset ? '0 : ALUCW'(alu3);
    assign LongStart  = ~reset && (st == EXECR || st == EXECI) && islong;
    assign FlagW      = (!reset && st == ALUWB) ? {Funct[0], Funct[0] & addsub} : 2'b00;
    assign PCS        = ((Rd == 4'hF) & RegW) | Branch;

endmodule
